ghist_ram_1r1w: RTL and testbench
=================================

GHIST_RAM_1R1W -- requirements
Module: ghist_ram_1r1w

Interface
REQ-001 SHALL have parameter DEPTH, default 40: number of entries, 2..1024.
REQ-002 SHALL have parameter WIDTH, default 5: data bits per entry, 1..256.
REQ-003 SHALL have parameter MASK_GRAN, default 1: bits per write-mask lane; WIDTH divisible by MASK_GRAN.
REQ-004 SHALL have parameter RD_LATENCY, default 1: read latency in cycles, legal values 1 or 2.
REQ-005 SHALL derive AW = max(1, clog2(DEPTH)) and MW = WIDTH/MASK_GRAN.
REQ-006 SHALL use one clock and a synchronous, active-low reset.
REQ-007 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset_n, input, 1: synchronous active-low reset.
REQ-009 SHALL have port R0_addr, input, AW: read address.
REQ-010 SHALL have port R0_en, input, 1: read request.
REQ-011 SHALL have port R0_data, output, WIDTH: read data.
REQ-012 SHALL have port R0_valid, output, 1: high when the returned entry has been written since reset.
REQ-013 SHALL have port W0_addr, input, AW: write address.
REQ-014 SHALL have port W0_en, input, 1: write request.
REQ-015 SHALL have port W0_data, input, WIDTH: write data.
REQ-016 SHALL have port W0_mask, input, MW: per-lane write enable; lane i covers bits [i*MASK_GRAN +: MASK_GRAN].

Function
REQ-017 SHALL sample R0_addr when R0_en=1 at edge t and present R0_data/R0_valid after edge t+RD_LATENCY-1, stable for the whole following cycle.
REQ-018 SHALL hold R0_data and R0_valid unchanged when no read completes in a cycle; no X is ever driven.
REQ-019 SHALL, with RD_LATENCY=2, pipeline the enable and hold each stage independently, sustaining one read per cycle.
REQ-020 SHALL, on W0_en=1 with W0_mask!=0, update only the masked lanes at that edge and set the entry's valid bit.
REQ-021 SHALL, on the first write to an invalid entry, clear the unmasked lanes to zero.
REQ-022 SHALL treat W0_en=1 with W0_mask=0 as a no-op; the valid bit is unchanged.
REQ-023 SHALL return zero data and R0_valid=0 for a read of an invalid entry.
REQ-024 SHALL bypass write-first per lane on a same-cycle read and write to the same address: masked lanes return W0_data, unmasked lanes return stored data (zero if the entry was invalid), and R0_valid=1.
REQ-025 SHALL drop writes with W0_addr >= DEPTH without side effects.
REQ-026 SHALL return zero and R0_valid=0 for reads with R0_addr >= DEPTH.
REQ-027 SHALL not bypass across different addresses; a read one cycle after a write to the same address sees the written value.

Reset
REQ-028 SHALL, while reset_n=0 at an edge, clear all entry valid bits, R0_data to 0, R0_valid to 0, and all read-pipeline enables.
REQ-029 SHALL ignore writes and reads presented in a reset cycle; reads in flight when reset asserts are discarded.
REQ-030 SHALL not reset storage contents; invalid-entry zeroing (REQ-023) makes this unobservable.
REQ-031 SHALL accept requests on the first edge with reset_n=1.

Structure
REQ-032 SHALL put the helper function for AW, parameter-legality checks, and the RD_LATENCY limits in shared package ghist_ram_pkg.
REQ-033 SHALL be a single module with no sub-modules; the storage array, valid vector, bypass mux, and read pipeline are all inline.
REQ-034 SHALL fail elaboration on illegal parameter combinations.

Verification (DEPTH=40, WIDTH=5, MASK_GRAN=1, RD_LATENCY=1 unless noted)
REQ-035 SHALL cover: reset; read addr 7 -> R0_data=0, R0_valid=0; write addr 7 data 5'h15 mask 5'h1F, then read 7 -> 5'h15, valid=1, one cycle after the read request.
REQ-036 SHALL cover: addr 3 holds 5'h1F; same-cycle write addr 3 data 5'h00 mask 5'h03 and read 3 -> R0_data=5'h1C.
REQ-037 SHALL cover: first write to invalid addr 9, data 5'h1F mask 5'h10 -> read 9 returns 5'h10, valid=1.
REQ-038 SHALL cover: write addr 45 data 5'h0A -> no entry changes; read addr 45 -> 0, valid=0; read addr 0..39 all unchanged.
REQ-039 SHALL cover: RD_LATENCY=2, back-to-back reads of addrs 1, 2, 3 holding 5'h01, 5'h02, 5'h03 -> data appears two cycles after each request, in order, with no bubbles.
REQ-040 SHALL cover: read issued, reset_n=0 the next cycle -> R0_data=0, R0_valid=0; after release, the previously written addr 7 reads 0 with valid=0.

Source files
------------

// File: rtl/ghist_ram_pkg.sv
// Shared parameters and elaboration helpers for the ghist_ram_1r1w history RAM.
// Holds the address-width function, parameter limits and the legality check.
package ghist_ram_pkg;

    localparam int RD_LATENCY_MIN = 1;
    localparam int RD_LATENCY_MAX = 2;
    localparam int DEPTH_MIN      = 2;
    localparam int DEPTH_MAX      = 1024;
    localparam int WIDTH_MIN      = 1;
    localparam int WIDTH_MAX      = 256;

    // Address width never drops below one bit, even for tiny depths.
    function automatic int addr_width(input int depth);
        int w;
        w = $clog2(depth);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic bit params_legal(input int depth, input int width,
                                        input int mask_gran, input int rd_latency);
        return (depth >= DEPTH_MIN) && (depth <= DEPTH_MAX) &&
               (width >= WIDTH_MIN) && (width <= WIDTH_MAX) &&
               (mask_gran >= 1) && (mask_gran <= width) &&
               ((width % mask_gran) == 0) &&
               (rd_latency >= RD_LATENCY_MIN) && (rd_latency <= RD_LATENCY_MAX);
    endfunction

endpackage

// File: rtl/ghist_ram_1r1w.sv
// One-read/one-write history RAM with per-entry valid bits, lane write masks,
// write-first same-address bypass and a 1- or 2-cycle registered read path.
module ghist_ram_1r1w
    import ghist_ram_pkg::*;
#(
    parameter  int DEPTH      = 40,
    parameter  int WIDTH      = 5,
    parameter  int MASK_GRAN  = 1,
    parameter  int RD_LATENCY = 1,
    localparam int AW         = addr_width(DEPTH),
    localparam int MW         = WIDTH / MASK_GRAN
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [AW-1:0]    R0_addr,
    input  logic             R0_en,
    output logic [WIDTH-1:0] R0_data,
    output logic             R0_valid,
    input  logic [AW-1:0]    W0_addr,
    input  logic             W0_en,
    input  logic [WIDTH-1:0] W0_data,
    input  logic [MW-1:0]    W0_mask
);

    if (!params_legal(DEPTH, WIDTH, MASK_GRAN, RD_LATENCY)) begin : g_param_check
        $error("ghist_ram_1r1w: illegal parameter combination");
    end

    localparam logic [AW:0] DEPTH_LIM = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [WIDTH-1:0] r_data;
    logic             r_out_valid;

    logic             w_wr_fire;
    logic             w_rd_in_range;
    logic             w_rd_stored_valid;
    logic             w_rd_hit;
    logic [WIDTH-1:0] w_rd_stored;
    logic [WIDTH-1:0] w_rd_data;
    logic             w_rd_valid;

    // Out-of-range and all-lanes-masked writes are dropped before touching state.
    assign w_wr_fire         = reset_n & W0_en & (|W0_mask) & ({1'b0, W0_addr} < DEPTH_LIM);
    assign w_rd_in_range     = {1'b0, R0_addr} < DEPTH_LIM;
    assign w_rd_stored_valid = w_rd_in_range && r_valid[R0_addr];
    assign w_rd_stored       = w_rd_stored_valid ? r_mem[R0_addr] : '0;
    assign w_rd_hit          = w_wr_fire && (R0_addr == W0_addr);
    assign w_rd_valid        = w_rd_stored_valid | w_rd_hit;

    // NOTE: default first so every path assigns w_rd_data and no latch is inferred.
    always_comb begin
        w_rd_data = w_rd_stored;
        if (w_rd_hit) begin
            for (int i = 0; i < MW; i++) begin
                if (W0_mask[i]) begin
                    w_rd_data[i*MASK_GRAN +: MASK_GRAN] = W0_data[i*MASK_GRAN +: MASK_GRAN];
                end
            end
        end
    end

    // NOTE: storage has no reset; the valid vector hides stale contents instead.
    always_ff @(posedge clock) begin
        if (w_wr_fire) begin
            for (int i = 0; i < MW; i++) begin
                if (W0_mask[i]) begin
                    r_mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= W0_data[i*MASK_GRAN +: MASK_GRAN];
                end else if (!r_valid[W0_addr]) begin
                    r_mem[W0_addr][i*MASK_GRAN +: MASK_GRAN] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_valid <= '0;
        end else if (w_wr_fire) begin
            r_valid[W0_addr] <= 1'b1;
        end
    end

    if (RD_LATENCY == 2) begin : g_lat2
        logic             r_s1_en;
        logic [WIDTH-1:0] r_s1_data;
        logic             r_s1_valid;

        // Each stage only loads when its own enable is set, so holes hold data.
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_s1_en     <= 1'b0;
                r_s1_data   <= '0;
                r_s1_valid  <= 1'b0;
                r_data      <= '0;
                r_out_valid <= 1'b0;
            end else begin
                r_s1_en <= R0_en;
                if (R0_en) begin
                    r_s1_data  <= w_rd_data;
                    r_s1_valid <= w_rd_valid;
                end
                if (r_s1_en) begin
                    r_data      <= r_s1_data;
                    r_out_valid <= r_s1_valid;
                end
            end
        end
    end else begin : g_lat1
        always_ff @(posedge clock) begin
            if (!reset_n) begin
                r_data      <= '0;
                r_out_valid <= 1'b0;
            end else if (R0_en) begin
                r_data      <= w_rd_data;
                r_out_valid <= w_rd_valid;
            end
        end
    end

    assign R0_data  = r_data;
    assign R0_valid = r_out_valid;

endmodule

// File: tb/tb_ghist_ram_1r1w.sv
// Scoreboard bench for ghist_ram_1r1w: one instance at read latency 1 and one at
// latency 2 share the same stimulus; a reference model predicts every read.
module tb_ghist_ram_1r1w;

    localparam int DEPTH = 40;
    localparam int WIDTH = 5;

    logic             clock   = 1'b0;
    logic             reset_n = 1'b0;
    logic [5:0]       R0_addr = '0;
    logic             R0_en   = 1'b0;
    logic [5:0]       W0_addr = '0;
    logic             W0_en   = 1'b0;
    logic [WIDTH-1:0] W0_data = '0;
    logic [WIDTH-1:0] W0_mask = '0;
    logic [WIDTH-1:0] d1, d2;
    logic             v1, v2;

    always #5 clock = ~clock;

    ghist_ram_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(1), .RD_LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(d1), .R0_valid(v1),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    ghist_ram_1r1w #(.DEPTH(DEPTH), .WIDTH(WIDTH), .MASK_GRAN(1), .RD_LATENCY(2)) dut2 (
        .clock(clock), .reset_n(reset_n),
        .R0_addr(R0_addr), .R0_en(R0_en), .R0_data(d2), .R0_valid(v2),
        .W0_addr(W0_addr), .W0_en(W0_en), .W0_data(W0_data), .W0_mask(W0_mask)
    );

    typedef struct {
        int               due;
        logic [WIDTH-1:0] d;
        logic             v;
        string            tag;
    } exp_t;

    exp_t             q1[$];
    exp_t             q2[$];
    int               cyc    = 0;
    bit               mon_on = 1'b0;
    logic [WIDTH-1:0] last_d1 = '0, last_d2 = '0;
    logic             last_v1 = 1'b0, last_v2 = 1'b0;
    logic [WIDTH-1:0] m_mem   [DEPTH];
    bit               m_valid [DEPTH];
    int               errors = 0;
    int               checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clock) cyc <= cyc + 1;

    // Completed reads are compared on the falling edge; otherwise outputs must hold.
    always @(negedge clock) begin
        exp_t e;
        if (mon_on) begin
            if (q1.size() > 0 && q1[0].due == cyc) begin
                e = q1.pop_front();
                check({e.tag, "_lat1_data"}, d1, e.d);
                check({e.tag, "_lat1_valid"}, v1, e.v);
                last_d1 = e.d;
                last_v1 = e.v;
            end else begin
                check("hold_lat1_data", d1, last_d1);
                check("hold_lat1_valid", v1, last_v1);
            end
            if (q2.size() > 0 && q2[0].due == cyc) begin
                e = q2.pop_front();
                check({e.tag, "_lat2_data"}, d2, e.d);
                check({e.tag, "_lat2_valid"}, v2, e.v);
                last_d2 = e.d;
                last_v2 = e.v;
            end else begin
                check("hold_lat2_data", d2, last_d2);
                check("hold_lat2_valid", v2, last_v2);
            end
        end
    end

    task automatic drive(input bit re, input int ra, input bit we, input int wa,
                         input logic [WIDTH-1:0] wd, input logic [WIDTH-1:0] wm,
                         input string tag);
        exp_t             e;
        logic [WIDTH-1:0] st;
        bit               hit;
        bit               sv;
        @(negedge clock);
        #1;
        reset_n = 1'b1;
        R0_en   = re;
        R0_addr = 6'(ra);
        W0_en   = we;
        W0_addr = 6'(wa);
        W0_data = wd;
        W0_mask = wm;
        if (re) begin
            sv    = (ra < DEPTH) && m_valid[ra];
            st    = sv ? m_mem[ra] : '0;
            hit   = we && (wm != 0) && (wa < DEPTH) && (wa == ra);
            e.d   = hit ? ((st & ~wm) | (wd & wm)) : st;
            e.v   = sv || hit;
            e.tag = tag;
            e.due = cyc + 1;
            q1.push_back(e);
            e.due = cyc + 2;
            q2.push_back(e);
        end
        if (we && (wm != 0) && (wa < DEPTH)) begin
            m_mem[wa]   = m_valid[wa] ? ((m_mem[wa] & ~wm) | (wd & wm)) : (wd & wm);
            m_valid[wa] = 1'b1;
        end
    endtask

    task automatic idle();
        drive(1'b0, 0, 1'b0, 0, '0, '0, "idle");
    endtask

    // Reset with a live read and write presented; both must be ignored.
    task automatic reset_cycles(input int n);
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        R0_en   = 1'b1;
        R0_addr = 6'd11;
        W0_en   = 1'b1;
        W0_addr = 6'd11;
        W0_data = 5'h1F;
        W0_mask = 5'h1F;
        q1.delete();
        q2.delete();
        last_d1 = '0;
        last_v1 = 1'b0;
        last_d2 = '0;
        last_v2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        repeat (n - 1) @(negedge clock);
    endtask

    initial begin
        int ra, wa;
        for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("reset_lat1_data", d1, 0);
        check("reset_lat1_valid", v1, 0);
        check("reset_lat2_data", d2, 0);
        check("reset_lat2_valid", v2, 0);
        mon_on = 1'b1;

        drive(1'b1, 7, 1'b0, 0, '0, '0, "rd7_invalid");
        drive(1'b0, 0, 1'b1, 7, 5'h15, 5'h1F, "wr7");
        drive(1'b1, 7, 1'b0, 0, '0, '0, "rd7_written");

        drive(1'b0, 0, 1'b1, 3, 5'h1F, 5'h1F, "wr3");
        idle();
        drive(1'b1, 3, 1'b1, 3, 5'h00, 5'h03, "bypass3");
        drive(1'b1, 3, 1'b0, 0, '0, '0, "rd3_after");

        drive(1'b0, 0, 1'b1, 9, 5'h1F, 5'h10, "wr9_first");
        drive(1'b1, 9, 1'b0, 0, '0, '0, "rd9");
        drive(1'b1, 12, 1'b1, 12, 5'h1F, 5'h06, "bypass12_invalid");

        drive(1'b0, 0, 1'b1, 20, 5'h1F, 5'h00, "wr20_nomask");
        drive(1'b1, 20, 1'b0, 0, '0, '0, "rd20");
        drive(1'b1, 20, 1'b1, 20, 5'h1F, 5'h00, "bypass20_nomask");

        drive(1'b0, 0, 1'b1, 45, 5'h0A, 5'h1F, "wr45");
        drive(1'b1, 45, 1'b0, 0, '0, '0, "rd45");
        for (int a = 0; a < DEPTH; a++) drive(1'b1, a, 1'b0, 0, '0, '0, "sweep");

        drive(1'b0, 0, 1'b1, 1, 5'h01, 5'h1F, "wr1");
        drive(1'b0, 0, 1'b1, 2, 5'h02, 5'h1F, "wr2");
        drive(1'b0, 0, 1'b1, 3, 5'h03, 5'h1F, "wr3b");
        drive(1'b1, 1, 1'b0, 0, '0, '0, "b2b1");
        drive(1'b1, 2, 1'b0, 0, '0, '0, "b2b2");
        drive(1'b1, 3, 1'b0, 0, '0, '0, "b2b3");
        idle();
        idle();

        for (int k = 0; k < 200; k++) begin
            ra = int'($urandom_range(0, 47));
            wa = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 47));
            drive(1'($urandom_range(0, 1)), ra, 1'($urandom_range(0, 1)), wa,
                  5'($urandom), 5'($urandom), "rand");
        end

        drive(1'b0, 0, 1'b1, 7, 5'h15, 5'h1F, "wr7_again");
        drive(1'b1, 7, 1'b0, 0, '0, '0, "rd7_pre_reset");
        reset_cycles(2);
        drive(1'b1, 7, 1'b0, 0, '0, '0, "rd7_post_reset");
        drive(1'b1, 11, 1'b0, 0, '0, '0, "rd11_post_reset");
        repeat (4) idle();

        check("drain_lat1", q1.size(), 0);
        check("drain_lat2", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
